// File: rtl/truth_table_checker.sv
// Collects (minterm, output) samples, builds the captured table and grades it against exp_table latched on start.
// Latency: results visible 1 cycle after each accept; done/pass 1 cycle after the last new minterm.
// Backpressure: in_ready is high only while collecting. Optional ascending-order check: CHK_ORDER_EN.
module truth_table_checker #(
    parameter int N_IN = 3,
    localparam int T = 1 << N_IN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [T-1:0]    exp_table,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_idx,
    input  logic            in_s,
    output logic [T-1:0]    cap_table,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_idx,
    output logic            first_err_vld,
    output logic            proto_err,
    output logic            done,
    output logic            pass
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic [T-1:0] exp_q;
    logic [T-1:0] seen;
    logic [T-1:0] seen_after;
    logic         accept;
    logic         dup;
    logic         mismatch;

    // A sample arriving together with start belongs to the old run and is dropped.
    assign accept     = in_valid && in_ready && !start;
    assign dup        = seen[in_idx];
    assign seen_after = seen | ({{(T-1){1'b0}}, 1'b1} << in_idx);
    assign mismatch   = !dup && (in_s != exp_q[in_idx]);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start)
                    next_state = COLLECT;
            end
            COLLECT: begin
                if (start)
                    next_state = COLLECT;
                else if (accept && (&seen_after))
                    next_state = DONE;
            end
            DONE: begin
                if (start)
                    next_state = COLLECT;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == COLLECT);
        done     = (state == DONE);
        pass     = (state == DONE) && (err_count == '0) && !proto_err;
    end

`ifdef CHK_ORDER_EN
    logic [N_IN-1:0] next_idx;

    always_ff @(posedge clk) begin
        if (reset || start)
            next_idx <= '0;
        else if (accept && (in_idx == next_idx))
            next_idx <= next_idx + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q         <= '0;
            seen          <= '0;
            cap_table     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
            proto_err     <= 1'b0;
        end else if (start) begin
            exp_q         <= exp_table;
            seen          <= '0;
            cap_table     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
            proto_err     <= 1'b0;
        end else if (accept) begin
            if (dup) begin
                proto_err <= 1'b1;
            end else begin
                seen              <= seen_after;
                cap_table[in_idx] <= in_s;
                if (mismatch) begin
                    err_count <= err_count + 1'b1;
                    if (!first_err_vld) begin
                        first_err_idx <= in_idx;
                        first_err_vld <= 1'b1;
                    end
                end
            end
`ifdef CHK_ORDER_EN
            if (in_idx != next_idx)
                proto_err <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: a set-based reference model checked every cycle plus literal expectations.
module tb_truth_table_checker;
    localparam int N_IN = 3;
    localparam int T = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [T-1:0]    exp_table;
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_idx;
    logic            in_s;
    logic [T-1:0]    cap_table;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_err_idx;
    logic            first_err_vld;
    logic            proto_err;
    logic            done;
    logic            pass;

    truth_table_checker #(.N_IN(N_IN)) dut (
        .clk(clk), .reset(reset), .start(start), .exp_table(exp_table),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_s(in_s),
        .cap_table(cap_table), .err_count(err_count), .first_err_idx(first_err_idx),
        .first_err_vld(first_err_vld), .proto_err(proto_err), .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // f(x,y,z) = (y & ~z) | (x & ~z), x is the index MSB
    function automatic logic f(input int m);
        logic [2:0] b;
        b = m[2:0];
        return (b[1] & ~b[0]) | (b[2] & ~b[0]);
    endfunction

    // Reference model: a run is a set of seen minterms; grading follows the rules directly.
    bit          m_collect, m_done, m_proto, m_fvld;
    bit [T-1:0]  m_exp, m_cap;
    bit          m_seen [T];
    int          m_err, m_first, m_next, m_nseen;

    always @(posedge clk) begin
        if (reset) begin
            m_collect = 0; m_done = 0; m_proto = 0; m_fvld = 0;
            m_exp = '0; m_cap = '0; m_err = 0; m_first = 0; m_next = 0; m_nseen = 0;
            foreach (m_seen[i]) m_seen[i] = 0;
        end else if (start) begin
            m_collect = 1; m_done = 0; m_proto = 0; m_fvld = 0;
            m_exp = exp_table; m_cap = '0; m_err = 0; m_first = 0; m_next = 0; m_nseen = 0;
            foreach (m_seen[i]) m_seen[i] = 0;
        end else if (m_collect && in_valid) begin
            int k;
            k = int'(in_idx);
            if (m_seen[k]) begin
                m_proto = 1;
            end else begin
                m_seen[k] = 1;
                m_nseen++;
                m_cap[k] = in_s;
                if (in_s != m_exp[k]) begin
                    m_err++;
                    if (!m_fvld) begin
                        m_fvld = 1;
                        m_first = k;
                    end
                end
            end
`ifdef CHK_ORDER_EN
            if (k != m_next) m_proto = 1;
            else m_next++;
`endif
            if (m_nseen == T) begin
                m_collect = 0;
                m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready", in_ready, m_collect);
            check("done", done, m_done);
            check("pass", pass, m_done && m_err == 0 && !m_proto);
            check("cap_table", cap_table, m_cap);
            check("err_count", err_count, m_err);
            check("first_err_vld", first_err_vld, m_fvld);
            check("first_err_idx", first_err_idx, m_first);
            check("proto_err", proto_err, m_proto);
        end
    end

    // All stimulus tasks are entered 1 time unit after a rising edge.
    task automatic do_start(input logic [T-1:0] e);
        exp_table = e;
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send(input int m, input logic s);
        in_valid = 1;
        in_idx = m[N_IN-1:0];
        in_s = s;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    initial begin
        reset = 1; start = 0; in_valid = 0; in_idx = '0; in_s = 0; exp_table = '0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        cmp_en = 1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_cap", cap_table, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;

        // Test 1: ascending, correct
        do_start(8'h54);
        for (int m = 0; m < 7; m++) send(m, f(m));
        in_valid = 1; in_idx = 3'd7; in_s = f(7);
        @(negedge clk);
        check("t1_done_before_last", done, 0);
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_pass", pass, 1);
        check("t1_cap", cap_table, 8'h54);
        check("t1_err", err_count, 0);
        check("t1_in_ready", in_ready, 0);
        @(posedge clk); #1;

        // Test 6: restart from DONE with an all-ones expectation
        do_start(8'hFF);
        for (int m = 0; m < T; m++) send(m, f(m));
        @(negedge clk);
        check("t6_err", err_count, 5);
        check("t6_first_idx", first_err_idx, 0);
        check("t6_pass", pass, 0);
        check("t6_done", done, 1);
        @(posedge clk); #1;

        // Test 2: single wrong output at m=5
        do_start(8'h54);
        for (int m = 0; m < T; m++) send(m, (m == 5) ? 1'b1 : f(m));
        @(negedge clk);
        check("t2_err", err_count, 1);
        check("t2_first_idx", first_err_idx, 5);
        check("t2_first_vld", first_err_vld, 1);
        check("t2_pass", pass, 0);
        @(posedge clk); #1;

        // Test 3: descending order
        do_start(8'h54);
        for (int m = T - 1; m >= 0; m--) send(m, f(m));
        @(negedge clk);
        check("t3_cap", cap_table, 8'h54);
        check("t3_done", done, 1);
`ifdef CHK_ORDER_EN
        check("t3_proto", proto_err, 1);
        check("t3_pass", pass, 0);
`else
        check("t3_proto", proto_err, 0);
        check("t3_pass", pass, 1);
`endif
        @(posedge clk); #1;

        // Test 4: start with a wrong sample alongside (must be ignored), then a duplicate 3
        in_valid = 1; in_idx = 3'd0; in_s = 1'b1;
        do_start(8'h54);
        in_valid = 0;
        @(negedge clk);
        check("t4_start_sample_cap", cap_table, 0);
        check("t4_start_sample_err", err_count, 0);
        @(posedge clk); #1;
        for (int m = 0; m < 4; m++) send(m, f(m));
        send(3, f(3));
        @(negedge clk);
        check("t4_proto_after_dup", proto_err, 1);
        check("t4_done_early", done, 0);
        @(posedge clk); #1;
        for (int m = 4; m < T; m++) send(m, f(m));
        @(negedge clk);
        check("t4_err", err_count, 0);
        check("t4_done", done, 1);
        check("t4_pass", pass, 0);
        @(posedge clk); #1;

        // Test 5: reset mid-run
        do_start(8'h54);
        for (int m = 0; m < 4; m++) send(m, f(m));
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check("t5_in_ready", in_ready, 0);
        check("t5_cap", cap_table, 0);
        check("t5_err", err_count, 0);
        check("t5_proto", proto_err, 0);
        check("t5_done", done, 0);
        check("t5_first_vld", first_err_vld, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
